// File: rtl/ascii_num_parser.sv
// Scans a validated ASCII buffer and turns space-separated, optionally negative
// decimal tokens into signed integers on a valid/ready stream.
module ascii_num_parser #(
    parameter int MAX_PAYLOAD = 2048,
    parameter int NUM_WIDTH   = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         start,
    input  logic [MAX_PAYLOAD-1:0][7:0]  char_buffer,
    input  logic [15:0]                  buffer_length,
    output logic [NUM_WIDTH-1:0]         num_data,
    output logic                         num_valid,
    input  logic                         num_ready,
    output logic [15:0]                  num_count,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);

    localparam int AW = $clog2(MAX_PAYLOAD);
    localparam int XW = NUM_WIDTH + 4;
    localparam logic [XW-1:0] NEG_LIM = XW'(1) << (NUM_WIDTH - 1);
    localparam logic [XW-1:0] POS_LIM = NEG_LIM - XW'(1);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        EMIT,
        DONE,
        ERROR
    } state_t;

    state_t               state, state_n;
    logic [15:0]          rd_ptr, rd_ptr_n;
    logic [NUM_WIDTH-1:0] mag, mag_n;
    logic                 neg, neg_n;
    logic                 in_num, in_num_n;
    logic                 sign_pend, sign_pend_n;
    logic [NUM_WIDTH-1:0] data_n;
    logic                 valid_n;
    logic [15:0]          count_n;

    logic [7:0]    ch;
    logic          is_digit;
    logic          at_end;
    logic [XW-1:0] next_mag;
    logic [XW-1:0] limit;

    assign ch       = char_buffer[rd_ptr[AW-1:0]];
    assign is_digit = (ch >= 8'h30) && (ch <= 8'h39);
    assign at_end   = (rd_ptr == buffer_length);
    assign next_mag = {4'b0, mag} * XW'(10) + XW'(ch[3:0]);
    assign limit    = neg ? NEG_LIM : POS_LIM;

    assign busy  = (state == SCAN) || (state == EMIT);
    assign done  = (state == DONE);
    assign error = (state == ERROR);

    always_comb begin
        state_n     = state;
        rd_ptr_n    = rd_ptr;
        mag_n       = mag;
        neg_n       = neg;
        in_num_n    = in_num;
        sign_pend_n = sign_pend;
        data_n      = num_data;
        valid_n     = num_valid;
        count_n     = num_count;
        unique case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    rd_ptr_n    = '0;
                    count_n     = '0;
                    mag_n       = '0;
                    neg_n       = 1'b0;
                    in_num_n    = 1'b0;
                    sign_pend_n = 1'b0;
                    valid_n     = 1'b0;
                    state_n     = (buffer_length > 16'(MAX_PAYLOAD)) ? ERROR : SCAN;
                end
            end
            SCAN: begin
                // A finished token is latched onto the stream on the same edge.
                if (at_end || (ch == 8'h20 && in_num)) begin
                    if (in_num) begin
                        data_n   = neg ? -mag : mag;
                        valid_n  = 1'b1;
                        mag_n    = '0;
                        neg_n    = 1'b0;
                        in_num_n = 1'b0;
                        state_n  = EMIT;
                        if (!at_end) rd_ptr_n = rd_ptr + 16'd1;
                    end else begin
                        state_n = sign_pend ? ERROR : DONE;
                    end
                end else if (is_digit) begin
                    if (next_mag > limit) begin
                        state_n = ERROR;
                    end else begin
                        mag_n       = next_mag[NUM_WIDTH-1:0];
                        in_num_n    = 1'b1;
                        sign_pend_n = 1'b0;
                        rd_ptr_n    = rd_ptr + 16'd1;
                    end
                end else if (ch == 8'h2D) begin
                    if (in_num || sign_pend) begin
                        state_n = ERROR;
                    end else begin
                        neg_n       = 1'b1;
                        sign_pend_n = 1'b1;
                        rd_ptr_n    = rd_ptr + 16'd1;
                    end
                end else if (ch == 8'h20 && !sign_pend) begin
                    rd_ptr_n = rd_ptr + 16'd1;
                end else begin
                    state_n = ERROR;
                end
            end
            EMIT: begin
                if (num_valid && num_ready) begin
                    valid_n = 1'b0;
                    count_n = num_count + 16'd1;
                    state_n = at_end ? DONE : SCAN;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            mag       <= '0;
            neg       <= 1'b0;
            in_num    <= 1'b0;
            sign_pend <= 1'b0;
            num_data  <= '0;
            num_valid <= 1'b0;
            num_count <= '0;
        end else if (clear) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            mag       <= '0;
            neg       <= 1'b0;
            in_num    <= 1'b0;
            sign_pend <= 1'b0;
            num_data  <= '0;
            num_valid <= 1'b0;
            num_count <= '0;
        end else begin
            state     <= state_n;
            rd_ptr    <= rd_ptr_n;
            mag       <= mag_n;
            neg       <= neg_n;
            in_num    <= in_num_n;
            sign_pend <= sign_pend_n;
            num_data  <= data_n;
            num_valid <= valid_n;
            num_count <= count_n;
        end
    end

endmodule

// File: tb/tb_ascii_num_parser.sv
// Randomised and directed bench for ascii_num_parser against a token-level
// reference model.
module tb_ascii_num_parser;

    localparam int MP = 2048;
    localparam int NW = 32;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 clear = 1'b0;
    logic                 start = 1'b0;
    logic                 num_ready = 1'b0;
    logic [MP-1:0][7:0]   char_buffer = '0;
    logic [15:0]          buffer_length = '0;
    logic [NW-1:0]        num_data;
    logic                 num_valid;
    logic [15:0]          num_count;
    logic                 busy;
    logic                 done;
    logic                 error;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_q[$];
    bit          exp_err;

    always #5 clk = ~clk;

    ascii_num_parser #(.MAX_PAYLOAD(MP), .NUM_WIDTH(NW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
        .char_buffer(char_buffer), .buffer_length(buffer_length),
        .num_data(num_data), .num_valid(num_valid), .num_ready(num_ready),
        .num_count(num_count), .busy(busy), .done(done), .error(error)
    );

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One token: optional leading '-', then at least one digit, within int32 range.
    function automatic bit token_value(string t, output longint v);
        bit     ng;
        int     s0;
        longint m;
        v  = 0;
        ng = (t.getc(0) == 8'h2D);
        s0 = ng ? 1 : 0;
        if (s0 >= t.len()) return 0;
        m = 0;
        for (int j = s0; j < t.len(); j++) begin
            byte c;
            c = t.getc(j);
            if (c < 8'h30 || c > 8'h39) return 0;
            m = m * 10 + longint'(c - 8'h30);
            if (m > 64'd2147483648) return 0;
        end
        if (!ng && m > 64'd2147483647) return 0;
        v = ng ? -m : m;
        return 1;
    endfunction

    function automatic void model(string s);
        int     st;
        longint v;
        exp_q.delete();
        exp_err = 0;
        st = -1;
        for (int i = 0; i <= s.len(); i++) begin
            bit sp;
            sp = (i == s.len()) || (s.getc(i) == 8'h20);
            if (!sp && st < 0) st = i;
            if (sp && st >= 0) begin
                if (!token_value(s.substr(st, i - 1), v)) begin
                    exp_err = 1;
                    return;
                end
                exp_q.push_back(v[31:0]);
                st = -1;
            end
        end
    endfunction

    task automatic load(string s);
        char_buffer = '0;
        for (int i = 0; i < s.len(); i++) char_buffer[i] = s.getc(i);
        buffer_length = 16'(s.len());
    endtask

    // mode 0: ready high, 1: random ready, 2: ready low for 5 cycles per number
    task automatic run_case(string s, int mode);
        int          n_exp;
        int          lowcnt;
        bit          stall;
        bit          fin;
        logic [31:0] pdata;
        model(s);
        n_exp  = exp_q.size();
        lowcnt = 0;
        stall  = 0;
        fin    = 0;
        pdata  = '0;
        load(s);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (done || error) begin
                fin = 1;
                break;
            end
            if (stall) begin
                check({"hold_valid ", s}, 64'(num_valid), 64'd1);
                check({"hold_data ", s}, 64'(num_data), 64'(pdata));
            end
            case (mode)
                0: num_ready = 1'b1;
                1: num_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (num_valid) begin
                        num_ready = (lowcnt >= 5);
                        lowcnt++;
                    end else begin
                        num_ready = 1'b0;
                        lowcnt = 0;
                    end
                end
            endcase
            if (num_valid && num_ready) begin
                if (exp_q.size() == 0) check({"extra_num ", s}, 64'(num_data), 64'hDEAD);
                else check({"num_data ", s}, 64'(num_data), 64'(exp_q.pop_front()));
            end
            stall = num_valid && !num_ready;
            pdata = num_data;
            @(negedge clk);
        end
        if (!fin) check({"timeout ", s}, 64'd0, 64'd1);
        check({"done ", s}, 64'(done), 64'(!exp_err));
        check({"error ", s}, 64'(error), 64'(exp_err));
        check({"count ", s}, 64'(num_count), 64'(n_exp));
        check({"left ", s}, 64'(exp_q.size()), 64'd0);
        check({"busy_end ", s}, 64'(busy), 64'd0);
        num_ready = 1'b0;
    endtask

    function automatic string rand_str();
        string s;
        int    nt;
        s  = "";
        nt = $urandom_range(0, 5);
        for (int k = 0; k < $urandom_range(0, 2); k++) s = {s, " "};
        for (int t = 0; t < nt; t++) begin
            int nd;
            if (t > 0) for (int k = 0; k < $urandom_range(1, 3); k++) s = {s, " "};
            if ($urandom_range(0, 2) == 0) s = {s, "-"};
            nd = $urandom_range(1, 11);
            for (int k = 0; k < nd; k++) begin
                s = {s, $sformatf("%0d", $urandom_range(0, 9))};
                if ($urandom_range(0, 40) == 0) s = {s, "-"};
            end
        end
        for (int k = 0; k < $urandom_range(0, 2); k++) s = {s, " "};
        return s;
    endfunction

    initial begin
        #1;
        check("rst_valid", 64'(num_valid), 64'd0);
        check("rst_count", 64'(num_count), 64'd0);
        check("rst_data", 64'(num_data), 64'd0);
        check("rst_flags", {61'd0, busy, done, error}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_case("12 -34 5", 0);
        run_case("  7   ", 2);
        run_case("-2147483648 2147483647", 0);
        run_case("2147483648", 1);
        run_case("-", 0);
        run_case("3 - 4", 0);
        run_case("1-2", 0);
        run_case("--5", 0);
        run_case("-0 0 2147483647 ", 2);

        // empty buffer
        load("");
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("empty_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("empty_done", 64'(done), 64'd1);
        check("empty_count", 64'(num_count), 64'd0);

        // oversized buffer
        buffer_length = 16'(MP + 1);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("long_error", 64'(error), 64'd1);
        check("long_busy", 64'(busy), 64'd0);

        // clear while a number is stalled
        load("100 200");
        num_ready = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < 20 && !num_valid; c++) @(negedge clk);
        check("clr_pre_valid", 64'(num_valid), 64'd1);
        check("clr_pre_data", 64'(num_data), 64'd100);
        clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        check("clr_valid", 64'(num_valid), 64'd0);
        check("clr_count", 64'(num_count), 64'd0);
        check("clr_flags", {62'd0, busy, done}, 64'd0);
        run_case("100 200", 1);

        // asynchronous reset mid-parse
        load("12 34");
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < 20 && !num_valid; c++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(num_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        for (int r = 0; r < 60; r++) run_case(rand_str(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ascii_num_parser.md
Name: ascii_num_parser

Overview:
- Stage directly downstream of the ASCII validator.
- After validation completes with no invalid characters, it scans the validated character buffer left to right. It converts space-separated, optionally negative decimal tokens into signed binary integers.
- Each number is emitted on a valid/ready stream to the matrix-loading logic. The block reports count, completion and format errors.

Parameters:
- MAX_PAYLOAD, 2048, depth of the character buffer it reads.
- NUM_WIDTH, 32, width of each signed output number (two's complement).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous abort; return to IDLE, zero all outputs
- start  input  1  one-cycle pulse: buffer is validated and stable; begin parsing
- char_buffer  input  8 x MAX_PAYLOAD  validated characters (digits, space, '-'); held stable from start until done/error
- buffer_length  input  16  number of valid characters in char_buffer
- num_data  output  NUM_WIDTH  parsed signed number
- num_valid  output  1  num_data valid
- num_ready  input  1  downstream accepts num_data
- num_count  output  16  numbers accepted by downstream since start
- busy  output  1  state is SCAN or EMIT
- done  output  1  level; parse finished without error
- error  output  1  level; format/overflow error detected

Behaviour:
- Reset / clear: state=IDLE; num_data=0, num_valid=0, num_count=0, busy=0, done=0, error=0. Internal registers are zeroed: rd_ptr, mag, neg, in_num, sign_pend. clear has priority over every other input, in every state.
- States: IDLE, SCAN, EMIT, DONE, ERROR.
- IDLE -> SCAN on start. Clears rd_ptr, num_count and the flags. If buffer_length > MAX_PAYLOAD, go to ERROR instead.
- start is ignored in any state other than IDLE, DONE or ERROR. In DONE/ERROR, start re-arms exactly as from IDLE.
- SCAN consumes one character per cycle at char_buffer[rd_ptr]:
  - rd_ptr == buffer_length (end of input):
    - if in_num -> EMIT;
    - else if sign_pend -> ERROR;
    - else -> DONE.
  - digit d: next = mag*10 + d, computed at NUM_WIDTH+4 bits. Limit is 2^(NUM_WIDTH-1)-1 if !neg, 2^(NUM_WIDTH-1) if neg. If next > limit -> ERROR. Otherwise mag=next, in_num=1, sign_pend=0, rd_ptr++.
  - '-': if in_num or sign_pend -> ERROR ("1-2", "--3"). Otherwise neg=1, sign_pend=1, rd_ptr++.
  - space:
    - if in_num -> EMIT, rd_ptr++;
    - else if sign_pend -> ERROR;
    - else skip, rd_ptr++.
    - Runs of spaces, and leading/trailing spaces, are skipped.
- Entry to EMIT: on the same edge, num_data = neg ? -mag : mag (NUM_WIDTH bits), num_valid=1. Then mag, neg and in_num clear.
- Latency: num_valid rises on the clock edge that consumes the terminating space or detects end of input.
- EMIT:
  - num_data and num_valid are held stable while num_valid && !num_ready.
  - On the num_valid && num_ready cycle: num_valid=0 next edge and num_count++. Then go to DONE if rd_ptr == buffer_length, else SCAN.
  - At most one number is in flight; there is no skid buffer.
- Throughput: one character per cycle, plus one EMIT cycle per number when ready is held high.
- DONE: done=1, busy=0. Outputs are held until clear or start.
- ERROR: error=1, busy=0, num_valid=0. num_count keeps the count accepted before the error. Outputs are held until clear or start.
- Empty buffer (buffer_length=0): SCAN sees end of input on its first cycle -> DONE with num_count=0.
- Asynchronous reset mid-parse returns everything to the reset values immediately. A number in flight is dropped.

Test Plan:
- "12 -34 5" (len 8), num_ready=1 -> stream 12, -34, 5; num_count=3; done=1; error=0; num_valid is never asserted for two cycles on the same value.
- "  7   " with num_ready low for 5 cycles after num_valid -> num_data=7 held stable for 5 cycles; accepted once; num_count=1; done=1.
- "-2147483648 2147483647" (NUM_WIDTH=32) -> 0x80000000 then 0x7FFFFFFF, done. Separately, "2147483648" -> error=1, num_count=0, no num_valid.
- Malformed inputs, each run separately: "-", "3 - 4", "1-2", "--5". Each gives error=1; num_count equals the numbers emitted before the fault ("3 - 4" -> 3 accepted, count=1).
- buffer_length=0 -> done one cycle after SCAN entry, num_count=0. buffer_length=2049 -> error=1 on the cycle after start.
- clear asserted while num_valid=1 and num_ready=0 mid "100 200" -> next cycle num_valid=0, num_count=0, state IDLE. A following start reparses and yields 100, 200.
